// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one decoder select path among 2**N requesters, with a hold limit.
// Latency: 1 clock from a request being sampled to its grant appearing; all outputs are registered.
// Backpressure: none; a requester keeps req high until it is served, and req is never latched.
module decoder_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int R       = 2 ** N,
  localparam int W       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [R-1:0] req,
  output logic [N-1:0] grant_idx,
  output logic         grant_en,
  output logic [R-1:0] gnt,
  output logic [W-1:0] hold_cnt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Last hold cycle before expiry; unused when MAX_HOLD is 0.
  localparam logic [W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : W'(MAX_HOLD - 1);
  // Saturation value for the unlimited-hold case.
  localparam logic [W-1:0] HOLD_SAT  = '1;

  state_t       state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic [N-1:0] last_q, last_d;
  logic         en_q, en_d;
  logic [W-1:0] hold_q, hold_d;
  logic [R-1:0] gnt_q, gnt_d;

  logic [N-1:0] win;
  logic [N-1:0] cand;
  logic         found;
  logic         any_req;
  logic         expire;

  // Round-robin search starting just after the last winner; the last winner is checked last.
  // While a grant is held, last equals the owner, so on expiry the owner only wins again
  // when nobody else is requesting.
  always_comb begin
    win     = last_q;
    cand    = '0;
    found   = 1'b0;
    any_req = |req;
    for (int k = 1; k <= R; k++) begin
      cand = last_q + N'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign expire = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // Next-state and next-output logic; release beats expiry, expiry beats hold.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    en_d    = en_q;
    hold_d  = hold_q;
    gnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          idx_d   = win;
          last_d  = win;
          en_d    = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          if (any_req) begin
            idx_d  = win;
            last_d = win;
            hold_d = '0;
          end else begin
            state_d = IDLE;
            en_d    = 1'b0;
          end
        end else if (expire) begin
          idx_d  = win;
          last_d = win;
          hold_d = '0;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
    if (en_d) begin
      gnt_d[idx_d] = 1'b1;
    end
  end

  // State and registered outputs; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= N'(R - 1);
      en_q    <= 1'b0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      en_q    <= en_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  assign grant_idx = idx_q;
  assign grant_en  = en_q;
  assign gnt       = gnt_q;
  assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter with N=2 (four requesters) and MAX_HOLD=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Each task drives its own scenario and compares against hand-computed values.
module tb_decoder_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [1:0] grant_idx;
  logic       grant_en;
  logic [3:0] gnt;
  logic [2:0] hold_cnt;

  int pass_cnt;
  int total_cnt;

  decoder_rr_arbiter #(.N(2), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant_idx (grant_idx),
    .grant_en  (grant_en),
    .gnt       (gnt),
    .hold_cnt  (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      step();
      total_cnt++;
      if (grant_en !== 1'b0 || gnt !== 4'b0000 || grant_idx !== 2'd0 || hold_cnt !== 3'd0)
        $display("FAIL reset_hold cyc%0d: en=%b gnt=%b idx=%0d hold=%0d, want en=0 gnt=0000 idx=0 hold=0",
                 c, grant_en, gnt, grant_idx, hold_cnt);
      else pass_cnt++;
    end
    reset = 1'b0;
    req   = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      total_cnt++;
      if (grant_en !== 1'b0 || gnt !== 4'b0000)
        $display("FAIL idle_no_req cyc%0d: en=%b gnt=%b, want en=0 gnt=0000", c, grant_en, gnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    step();
    total_cnt++;
    if (grant_idx !== 2'd2 || gnt !== 4'b0100 || grant_en !== 1'b1 || hold_cnt !== 3'd0)
      $display("FAIL single_grant: idx=%0d gnt=%b en=%b hold=%0d, want idx=2 gnt=0100 en=1 hold=0",
               grant_idx, gnt, grant_en, hold_cnt);
    else pass_cnt++;
    for (int c = 1; c <= 2; c++) begin
      step();
      total_cnt++;
      if (gnt !== 4'b0100 || hold_cnt !== 3'(c))
        $display("FAIL single_hold cyc%0d: gnt=%b hold=%0d, want gnt=0100 hold=%0d", c, gnt, hold_cnt, c);
      else pass_cnt++;
    end
    req = 4'b0000;
    step();
    total_cnt++;
    if (gnt !== 4'b0000 || grant_en !== 1'b0 || grant_idx !== 2'd2)
      $display("FAIL single_release: gnt=%b en=%b idx=%0d, want gnt=0000 en=0 idx=2", gnt, grant_en, grant_idx);
    else pass_cnt++;
  endtask

  task automatic test_rotate();
    logic [1:0] exp_idx;
    logic [3:0] exp_gnt;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      exp_idx = 2'((c / 4) % 4);
      exp_gnt = 4'b0001 << exp_idx;
      total_cnt++;
      if (grant_idx !== exp_idx || gnt !== exp_gnt || grant_en !== 1'b1 || hold_cnt !== 3'(c % 4))
        $display("FAIL rotate cyc%0d: idx=%0d gnt=%b en=%b hold=%0d, want idx=%0d gnt=%b en=1 hold=%0d",
                 c, grant_idx, gnt, grant_en, hold_cnt, exp_idx, exp_gnt, c % 4);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0011;
    step();
    step();
    total_cnt++;
    if (gnt !== 4'b0001 || hold_cnt !== 3'd1)
      $display("FAIL b2b_owner0: gnt=%b hold=%0d, want gnt=0001 hold=1", gnt, hold_cnt);
    else pass_cnt++;
    req = 4'b0010;
    step();
    total_cnt++;
    if (gnt !== 4'b0010 || hold_cnt !== 3'd0 || grant_en !== 1'b1 || grant_idx !== 2'd1)
      $display("FAIL b2b_handoff: gnt=%b hold=%0d en=%b idx=%0d, want gnt=0010 hold=0 en=1 idx=1",
               gnt, hold_cnt, grant_en, grant_idx);
    else pass_cnt++;
  endtask

  task automatic test_expiry_alone();
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 9; c++) begin
      step();
      total_cnt++;
      if (gnt !== 4'b1000 || grant_en !== 1'b1 || hold_cnt !== 3'(c % 4))
        $display("FAIL expiry_alone cyc%0d: gnt=%b en=%b hold=%0d, want gnt=1000 en=1 hold=%0d",
                 c, gnt, grant_en, hold_cnt, c % 4);
      else pass_cnt++;
    end
  endtask

  task automatic test_release_at_expiry();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 4; c++) step();
    total_cnt++;
    if (gnt !== 4'b0001 || hold_cnt !== 3'd3)
      $display("FAIL rel_exp_pre: gnt=%b hold=%0d, want gnt=0001 hold=3", gnt, hold_cnt);
    else pass_cnt++;
    req = 4'b0000;
    step();
    total_cnt++;
    if (gnt !== 4'b0000 || grant_en !== 1'b0)
      $display("FAIL rel_exp_release: gnt=%b en=%b, want gnt=0000 en=0", gnt, grant_en);
    else pass_cnt++;
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b0111;
    for (int c = 1; c <= 3; c++) begin
      step();
      total_cnt++;
      if (gnt !== 4'b0100 || hold_cnt !== 3'(c))
        $display("FAIL no_preempt cyc%0d: gnt=%b hold=%0d, want gnt=0100 hold=%0d", c, gnt, hold_cnt, c);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (gnt !== 4'b0001 || grant_idx !== 2'd0 || hold_cnt !== 3'd0 || grant_en !== 1'b1)
      $display("FAIL expiry_wrap: gnt=%b idx=%0d hold=%0d en=%b, want gnt=0001 idx=0 hold=0 en=1",
               gnt, grant_idx, hold_cnt, grant_en);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    step();
    step();
    total_cnt++;
    if (gnt !== 4'b0100 || hold_cnt !== 3'd1)
      $display("FAIL midrst_pre: gnt=%b hold=%0d, want gnt=0100 hold=1", gnt, hold_cnt);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (grant_en !== 1'b0 || gnt !== 4'b0000 || grant_idx !== 2'd0 || hold_cnt !== 3'd0)
      $display("FAIL midrst_async: en=%b gnt=%b idx=%0d hold=%0d, want en=0 gnt=0000 idx=0 hold=0",
               grant_en, gnt, grant_idx, hold_cnt);
    else pass_cnt++;
    #1;
    reset = 1'b0;
    req   = 4'b1111;
    step();
    total_cnt++;
    if (gnt !== 4'b0001 || grant_idx !== 2'd0 || grant_en !== 1'b1)
      $display("FAIL midrst_restart: gnt=%b idx=%0d en=%b, want gnt=0001 idx=0 en=1", gnt, grant_idx, grant_en);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    req       = 4'b0000;
    test_reset();
    test_single();
    test_rotate();
    test_back_to_back();
    test_expiry_alone();
    test_release_at_expiry();
    test_no_preempt();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
